// File: rtl/ahblite_uart_pkg.sv
// Shared constants and types for the AHB-Lite UART transmitter.
package ahblite_uart_pkg;

  // Register offsets decoded from HADDR[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;

  // AHB transfer encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Serialiser states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A divider of zero would give a one-cycle bit; clamp it to one
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/ahblite_uart_fifo.sv
// Byte-wide synchronous FIFO with same-cycle push and pop.
module ahblite_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  // A push into a full FIFO is only allowed when a pop frees the slot in the same cycle
  assign do_pop_s  = pop_i & (count_q != '0);
  assign do_push_s = push_i & ((count_q != FULL_CNT) | do_pop_s);

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push_s && !do_pop_s)      count_q <= count_q + 1'b1;
      else if (do_pop_s && !do_push_s) count_q <= count_q - 1'b1;
      else                             count_q <= count_q;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ahblite_uart_tx.sv
// AHB-Lite memory-mapped UART transmitter: bus data phase, registers, 8N1 serialiser.
module ahblite_uart_tx
  import ahblite_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RST   = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        TXD,
  output logic        TX_IRQ
);
  // Data-phase state
  logic        dp_valid_q;
  logic        dp_write_q;
  logic [1:0]  dp_addr_q;
  logic        err1_q;
  logic        err2_q;
  logic [15:0] baud_q;

  // Serialiser state
  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;

  logic        accept_s, legal_s, data_wr_s, frame_end_s;
  logic        hreadyout_s;
  logic [31:0] hrdata_s;
  logic        fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_rdata_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic        unused_s;

  assign unused_s    = ^{HADDR[31:4], HWDATA[31:16]};
  assign accept_s    = HSEL & HREADY & HTRANS[1];
  assign legal_s     = (HSIZE == HSIZE_WORD) & (HADDR[1:0] == 2'b00) & (HADDR[3:2] != OFF_RSVD);
  assign data_wr_s   = dp_valid_q & dp_write_q & (dp_addr_q == OFF_DATA);
  assign frame_end_s = (state_q == TX_STOP) & (cnt_q == 16'd0);
  assign fifo_pop_s  = ~fifo_empty_s & ((state_q == TX_IDLE) | frame_end_s);
  assign fifo_push_s = data_wr_s & (~fifo_full_s | fifo_pop_s);

  ahblite_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (fifo_push_s),
    .wdata_i (HWDATA[7:0]),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Stall on the first error cycle and on a DATA write into a full FIFO with no pop this cycle
  always_comb begin
    hreadyout_s = 1'b1;
    if (err1_q)                                        hreadyout_s = 1'b0;
    else if (data_wr_s && fifo_full_s && !fifo_pop_s)  hreadyout_s = 1'b0;
    else                                               hreadyout_s = 1'b1;
  end

  // Read data mux from the captured data-phase offset
  always_comb begin
    hrdata_s = 32'd0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        OFF_STATUS: begin
          hrdata_s[STAT_BUSY]  = (state_q != TX_IDLE);
          hrdata_s[STAT_EMPTY] = fifo_empty_s;
          hrdata_s[STAT_FULL]  = fifo_full_s;
        end
        OFF_BAUD: hrdata_s = {16'd0, baud_q};
        default:  hrdata_s = 32'd0;
      endcase
    end else begin
      hrdata_s = 32'd0;
    end
  end

  // Address-phase capture, two-cycle error sequencing and BAUDDIV register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
      err1_q     <= 1'b0;
      err2_q     <= 1'b0;
      baud_q     <= BAUD_RST;
    end else begin
      if (err1_q) begin
        err1_q     <= 1'b0;
        err2_q     <= 1'b1;
        dp_valid_q <= 1'b0;
      end else if (hreadyout_s) begin
        dp_valid_q <= accept_s & legal_s;
        err1_q     <= accept_s & ~legal_s;
        err2_q     <= 1'b0;
        dp_write_q <= HWRITE;
        dp_addr_q  <= HADDR[3:2];
      end else begin
        dp_valid_q <= dp_valid_q;
      end
      if (dp_valid_q && dp_write_q && (dp_addr_q == OFF_BAUD)) baud_q <= HWDATA[15:0];
    end
  end

  // 8N1 serialiser; divider is latched at each frame start so in-flight frames keep their rate
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= TX_IDLE;
      cnt_q   <= 16'd0;
      div_q   <= eff_div(BAUD_RST);
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (fifo_pop_s) begin
            state_q <= TX_START;
            cnt_q   <= eff_div(baud_q);
            div_q   <= eff_div(baud_q);
            shift_q <= fifo_rdata_s;
            txd_q   <= 1'b0;
          end else begin
            txd_q   <= 1'b1;
          end
        end
        TX_START: begin
          if (cnt_q == 16'd0) begin
            state_q <= TX_DATA;
            cnt_q   <= div_q;
            bit_q   <= 3'd0;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q   <= cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= div_q;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt_q == 16'd0) begin
            if (fifo_pop_s) begin
              state_q <= TX_START;
              cnt_q   <= eff_div(baud_q);
              div_q   <= eff_div(baud_q);
              shift_q <= fifo_rdata_s;
              txd_q   <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_s;
  assign HRESP     = err1_q | err2_q;
  assign HRDATA    = hrdata_s;
  assign TXD       = txd_q;
  assign TX_IRQ    = (fifo_count_s == '0) & (state_q == TX_IDLE);

endmodule

// File: tb/tb_ahblite_uart_tx.sv
// Directed, table-driven bench for ahblite_uart_tx (FIFO_DEPTH=4, BAUDDIV=3 during serial tests).
module tb_ahblite_uart_tx;
  import ahblite_uart_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        TXD;
  logic        TX_IRQ;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_starts = 0;
  int last_start = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];

  ahblite_uart_tx #(.FIFO_DEPTH(4), .BAUD_RST(16'd433)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .TXD(TXD), .TX_IRQ(TX_IRQ)
  );

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Single transfer; entered and left at #1 after a rising edge with the bus idle
  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic rdy1, output logic resp1,
                          output logic respf, output int waits, output logic [31:0] rdata);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wdata;
    rdy1 = HREADYOUT; resp1 = HRESP; waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 200) begin @(posedge HCLK); #1; waits++; end
    respf = HRESP; rdata = HRDATA;
    @(posedge HCLK); #1;
  endtask

  logic [7:0] burst_bytes [5];
  int         burst_waits [5];
  int         burst_done;

  // Five pipelined DATA writes; the next address is held while the current data phase stalls
  task automatic burst5();
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    for (int k = 0; k < 5; k++) begin
      @(posedge HCLK); #1;
      HWDATA = {24'd0, burst_bytes[k]};
      if (k == 4) begin HSEL = 1'b0; HTRANS = HTRANS_IDLE; end
      burst_waits[k] = 0;
      while (HREADYOUT !== 1'b1 && burst_waits[k] < 200) begin @(posedge HCLK); #1; burst_waits[k]++; end
      burst_done = cyc;
    end
    @(posedge HCLK); #1;
  endtask

  // Frame decoder, valid while the bit period is 4 cycles; samples the middle of each bit
  initial begin : monitor
    logic [7:0] b;
    int st;
    forever begin
      @(negedge HCLK);
      if (TXD === 1'b0) begin
        st = cyc; start_q.push_back(st); last_start = st; n_starts++;
        repeat (6) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
          b[i] = TXD;
          if (i < 7) repeat (4) @(negedge HCLK);
        end
        repeat (4) @(negedge HCLK);
        rx_q.push_back(b);
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin : main
    logic rdy1, resp1, respf;
    int w, n0, t, s0;
    logic [31:0] rd;
    logic [39:0] frame_bits;
    logic [7:0]  exp_bytes [7];

    vecs[0]  = '{1'b0, 32'h4, 3'b010, 32'h0,        1'b0, 32'h2};
    vecs[1]  = '{1'b0, 32'h8, 3'b010, 32'h0,        1'b0, 32'h3};
    vecs[2]  = '{1'b1, 32'h8, 3'b010, 32'h1234,     1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h8, 3'b010, 32'h0,        1'b0, 32'h1234};
    vecs[4]  = '{1'b1, 32'h8, 3'b010, 32'hABCD0005, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h8, 3'b010, 32'h0,        1'b0, 32'h5};
    vecs[6]  = '{1'b0, 32'h0, 3'b010, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h4, 3'b010, 32'hFF,       1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h4, 3'b010, 32'h0,        1'b0, 32'h2};
    vecs[9]  = '{1'b0, 32'hC, 3'b010, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0, 3'b000, 32'h5A,       1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h4, 3'b010, 32'h0,        1'b0, 32'h2};
    vecs[12] = '{1'b1, 32'h2, 3'b010, 32'h5A,       1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'h8, 3'b010, 32'h3,        1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h8, 3'b010, 32'h0,        1'b0, 32'h3};
    vecs[15] = '{1'b1, 32'hC, 3'b010, 32'h77,       1'b1, 32'h0};
    vecs[16] = '{1'b0, 32'h4, 3'b010, 32'h0,        1'b0, 32'h2};

    // Reset and idle outputs
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE;
    HSIZE = HSIZE_WORD; HWRITE = 1'b0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    chk("rst_hresp",     {31'd0, HRESP},     32'h0);
    chk("rst_hrdata",    HRDATA,             32'h0);
    chk("rst_txd",       {31'd0, TXD},       32'h1);
    chk("rst_irq",       {31'd0, TX_IRQ},    32'h1);
    HRESET = 1'b0;
    bus_xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rdy1, resp1, respf, w, rd);
    chk("rst_baud", rd, 32'h1B1);

    // Single 0xA5 frame at BAUDDIV=3, checked cycle by cycle
    bus_xfer(1'b1, 32'h8, HSIZE_WORD, 32'h3, rdy1, resp1, respf, w, rd);
    bus_xfer(1'b1, 32'h0, HSIZE_WORD, 32'hA5, rdy1, resp1, respf, w, rd);
    chk("t1_write_ready", {31'd0, rdy1}, 32'h1);
    t = 0;
    while (TXD !== 1'b0 && t < 10) begin @(posedge HCLK); #1; t++; end
    chk("t1_start_timeout", 32'(t < 10), 32'h1);
    chk("t1_irq_busy", {31'd0, TX_IRQ}, 32'h0);
    frame_bits = {{4{1'b1}}, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}},
                  {4{1'b0}}, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}}};
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 1) chk($sformatf("t1_txd_c%0d", i), {31'd0, TXD}, {31'd0, frame_bits[i]});
      @(posedge HCLK); #1;
    end
    chk("t1_txd_idle", {31'd0, TXD},    32'h1);
    chk("t1_irq_idle", {31'd0, TX_IRQ}, 32'h1);

    // Register-access vectors: legal reads/writes and two-cycle errors
    for (int i = 0; i < NV; i++) begin
      bus_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rdy1, resp1, respf, w, rd);
      chk($sformatf("v%0d_ready1", i), {31'd0, rdy1},  {31'd0, ~vecs[i].err});
      chk($sformatf("v%0d_resp1", i),  {31'd0, resp1}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_resp2", i),  {31'd0, respf}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_waits", i),  32'(w),         {31'd0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i),  rd,             vecs[i].rdata);
    end
    chk("pre_burst_rx_count", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) chk("t1_rx_byte", {24'd0, rx_q[0]}, 32'hA5);
    rx_q.delete();
    start_q.delete();

    // One byte in flight, then five pipelined writes: the fifth stalls until the stop-bit pop
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    n0 = n_starts;
    bus_xfer(1'b1, 32'h0, HSIZE_WORD, 32'h11, rdy1, resp1, respf, w, rd);
    t = 0;
    while (n_starts == n0 && t < 20) begin @(posedge HCLK); #1; t++; end
    chk("t2_first_start", 32'(t < 20), 32'h1);
    s0 = last_start;
    for (int k = 0; k < 5; k++) burst_bytes[k] = exp_bytes[k+1];
    burst5();
    for (int k = 0; k < 4; k++) chk($sformatf("t2_w%0d_waits", k), 32'(burst_waits[k]), 32'h0);
    chk("t2_w4_stalled", 32'(burst_waits[4] > 0), 32'h1);
    chk("t2_w4_done_cyc", 32'(burst_done), 32'(s0 + 39));

    // DATA write into a full FIFO exactly in the pop cycle completes with no wait
    t = 0;
    while (cyc < s0 + 78 && t < 100) begin @(posedge HCLK); #1; t++; end
    bus_xfer(1'b1, 32'h0, HSIZE_WORD, 32'h77, rdy1, resp1, respf, w, rd);
    chk("t6_ready1", {31'd0, rdy1}, 32'h1);
    chk("t6_waits",  32'(w),        32'h0);
    bus_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rdy1, resp1, respf, w, rd);
    chk("t6_status_full_busy", rd, 32'h5);

    // Drain and compare the serial stream
    t = 0;
    while (TX_IRQ !== 1'b1 && t < 1000) begin @(posedge HCLK); #1; t++; end
    chk("drain_timeout", 32'(t < 1000), 32'h1);
    chk("rx_count", 32'(rx_q.size()), 32'h7);
    for (int k = 0; k < 7 && k < rx_q.size(); k++)
      chk($sformatf("rx_byte%0d", k), {24'd0, rx_q[k]}, {24'd0, exp_bytes[k]});
    for (int k = 1; k < 7 && k < start_q.size(); k++)
      chk($sformatf("rx_gap%0d", k), 32'(start_q[k] - start_q[k-1]), 32'd40);

    // Reset in the middle of a data bit with bytes queued
    n0 = n_starts;
    bus_xfer(1'b1, 32'h0, HSIZE_WORD, 32'h3C, rdy1, resp1, respf, w, rd);
    bus_xfer(1'b1, 32'h0, HSIZE_WORD, 32'hC3, rdy1, resp1, respf, w, rd);
    t = 0;
    while (n_starts == n0 && t < 20) begin @(posedge HCLK); #1; t++; end
    chk("t5_start", 32'(t < 20), 32'h1);
    s0 = last_start;
    bus_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rdy1, resp1, respf, w, rd);
    chk("t5_status_busy", rd, 32'h4);
    t = 0;
    while (cyc < s0 + 10 && t < 50) begin @(posedge HCLK); #1; t++; end
    chk("t5_txd_bit1", {31'd0, TXD}, 32'h0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    chk("t5_txd_after_rst", {31'd0, TXD},       32'h1);
    chk("t5_irq_after_rst", {31'd0, TX_IRQ},    32'h1);
    chk("t5_rdy_after_rst", {31'd0, HREADYOUT}, 32'h1);
    HRESET = 1'b0;
    bus_xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rdy1, resp1, respf, w, rd);
    chk("t5_status", rd, 32'h2);
    bus_xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rdy1, resp1, respf, w, rd);
    chk("t5_baud", rd, 32'h1B1);
    t = 0;
    for (int i = 0; i < 60; i++) begin
      if (TXD !== 1'b1) t++;
      @(posedge HCLK); #1;
    end
    chk("t5_txd_stays_idle", 32'(t), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
